// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with valid/ready on both sides.
// Adds occupancy count, almost-full/empty flags, flush and a high-water mark.
module stream_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    max_level,
  input  logic             max_clr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    max_q, max_d;
  logic             push, pop;

  // Flush forces both handshakes low, so no transfer can coincide with it.
  assign s_ready = (count_q != CW'(DEPTH)) && !flush;
  assign m_valid = (count_q != '0) && !flush;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign m_data       = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign max_level    = max_q;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    max_d    = max_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
    // The high-water mark tracks the post-edge occupancy, not the current one.
    if (max_clr) begin
      max_d = count_d;
    end else if (count_d > max_q) begin
      max_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
      if (push) begin
        mem_q[wr_ptr_q] <= s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= CW'(DEPTH));
    end
  end

endmodule
